// File: rtl/ll_fifo_drain_arbiter.sv
// Drains a shared linked-list multi-queue FIFO: round-robin pop over non-empty enabled queues into a 2-entry skid buffer.
// Latency 1 cycle pop-to-out_valid; pops stall whenever the buffer holds 2 words, independent of out_ready.
module ll_fifo_drain_arbiter #(
    parameter int WIDTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_pop,
    output logic [SEL_WIDTH-1:0] fifo_pop_sel,
    input  logic [NUM_FIFOS-1:0] q_enable,
    input  logic                 stop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_qid,
    output logic                 idle,
    output logic [CNT_WIDTH-1:0] pop_total
);

    localparam int PAD = 1 << SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] LAST_Q = SEL_WIDTH'(NUM_FIFOS - 1);

    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 wr_idx_q, wr_idx_d;
    logic                 rd_idx_q, rd_idx_d;
    logic [1:0]           occ_q, occ_d;
    logic [CNT_WIDTH-1:0] pop_total_q, pop_total_d;
    logic [WIDTH-1:0]     buf_dat_q [2];
    logic [WIDTH-1:0]     buf_dat_d [2];
    logic [SEL_WIDTH-1:0] buf_qid_q [2];
    logic [SEL_WIDTH-1:0] buf_qid_d [2];

    logic [PAD-1:0]       elig;
    logic                 grant_vld;
    logic [SEL_WIDTH-1:0] grant_q;
    logic [SEL_WIDTH-1:0] scan_q;
    logic                 pop;
    logic                 accept;

    // Select codes beyond NUM_FIFOS stay zero so they can never win the scan.
    always_comb begin
        elig = '0;
        elig[NUM_FIFOS-1:0] = ~fifo_empty & q_enable;
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_q   = rr_ptr_q;
        scan_q    = rr_ptr_q;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (!grant_vld && elig[scan_q]) begin
                grant_vld = 1'b1;
                grant_q   = scan_q;
            end
            scan_q = (scan_q == LAST_Q) ? '0 : scan_q + SEL_WIDTH'(1);
        end
    end

    assign pop    = ~rst & ~stop & grant_vld & ~occ_q[1];
    assign accept = (occ_q != 2'd0) & out_ready;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        wr_idx_d    = wr_idx_q ^ pop;
        rd_idx_d    = rd_idx_q ^ accept;
        occ_d       = occ_q;
        pop_total_d = pop_total_q;
        buf_dat_d   = buf_dat_q;
        buf_qid_d   = buf_qid_q;
        if (pop) begin
            rr_ptr_d            = (grant_q == LAST_Q) ? '0 : grant_q + SEL_WIDTH'(1);
            buf_dat_d[wr_idx_q] = fifo_data;
            buf_qid_d[wr_idx_q] = grant_q;
            if (pop_total_q != '1) begin
                pop_total_d = pop_total_q + CNT_WIDTH'(1);
            end
        end
        case ({pop, accept})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wr_idx_q    <= 1'b0;
            rd_idx_q    <= 1'b0;
            occ_q       <= 2'd0;
            pop_total_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            occ_q       <= occ_d;
            pop_total_q <= pop_total_d;
        end
    end

    // Payload storage is qualified by occ, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_dat_q <= buf_dat_d;
        buf_qid_q <= buf_qid_d;
    end

    assign fifo_pop     = pop;
    assign fifo_pop_sel = (NUM_FIFOS == 1) ? '0 : (pop ? grant_q : rr_ptr_q);
    assign out_valid    = (occ_q != 2'd0);
    assign out_data     = buf_dat_q[rd_idx_q];
    assign out_qid      = (NUM_FIFOS == 1) ? '0 : buf_qid_q[rd_idx_q];
    assign idle         = stop & (occ_q == 2'd0);
    assign pop_total    = pop_total_q;

endmodule

// File: tb/tb_ll_fifo_drain_arbiter.sv
// Directed bench for ll_fifo_drain_arbiter with a two-queue shared FIFO model driving empty/data.
module tb_ll_fifo_drain_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fifo_empty;
    logic [3:0]  fifo_data;
    logic        fifo_pop;
    logic [0:0]  fifo_pop_sel;
    logic [1:0]  q_enable;
    logic        stop;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [0:0]  out_qid;
    logic        idle;
    logic [15:0] pop_total;

    int vectors = 0;
    int miscompares = 0;

    ll_fifo_drain_arbiter dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop), .fifo_pop_sel(fifo_pop_sel), .q_enable(q_enable),
        .stop(stop), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_qid(out_qid), .idle(idle), .pop_total(pop_total)
    );

    always #5 clk = ~clk;

    // Shared FIFO model: two circular queues, head presented combinationally for the selected queue.
    logic [3:0] mem0 [64];
    logic [3:0] mem1 [64];
    logic [5:0] hd0 = '0, hd1 = '0, tl0 = '0, tl1 = '0;

    assign fifo_empty = {hd1 == tl1, hd0 == tl0};
    assign fifo_data  = (fifo_pop_sel == 1'b1) ? mem1[hd1] : mem0[hd0];

    always @(posedge clk) begin
        if (!rst && fifo_pop) begin
            if (fifo_pop_sel == 1'b1) hd1 <= hd1 + 6'd1;
            else                      hd0 <= hd0 + 6'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (fifo_pop && fifo_empty[fifo_pop_sel]) begin
                miscompares++;
                $display("FAIL pop_of_empty sel=%0d empty=%b at %0t", fifo_pop_sel, fifo_empty, $time);
            end
        end
    end

    task automatic push0(input logic [3:0] v);
        mem0[tl0] = v;
        tl0 = tl0 + 6'd1;
    endtask

    task automatic push1(input logic [3:0] v);
        mem1[tl1] = v;
        tl1 = tl1 + 6'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stop = 1'b0; q_enable = 2'b11; out_ready = 1'b0;
        tick(); tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        vectors++; if (fifo_pop !== 1'b0) begin miscompares++; $display("FAIL rst_pop got=%b exp=0", fifo_pop); end
        vectors++; if (pop_total !== 16'd0) begin miscompares++; $display("FAIL rst_total got=%0d exp=0", pop_total); end
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL rst_idle_nostop got=%b exp=0", idle); end
        stop = 1'b1; #1;
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle_stop got=%b exp=1", idle); end
        rst = 1'b0; tick();
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL post_rst_idle got=%b exp=1", idle); end
    endtask

    task automatic test_round_robin();
        logic [3:0] ed [8];
        ed = '{4'h1, 4'h5, 4'h2, 4'h6, 4'h3, 4'h7, 4'h4, 4'h8};
        push0(4'h1); push0(4'h2); push0(4'h3); push0(4'h4);
        push1(4'h5); push1(4'h6); push1(4'h7); push1(4'h8);
        out_ready = 1'b1; stop = 1'b0; #1;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'(k % 2)) begin miscompares++; $display("FAIL rr_pop[%0d] got=%b/%0d exp=1/%0d", k, fifo_pop, fifo_pop_sel, k % 2); end
            end else begin
                vectors++; if (fifo_pop !== 1'b0) begin miscompares++; $display("FAIL rr_drained_pop got=%b exp=0", fifo_pop); end
            end
            if (k > 0) begin
                vectors++; if (out_valid !== 1'b1 || out_data !== ed[k-1] || out_qid !== 1'((k-1) % 2)) begin miscompares++; $display("FAIL rr_out[%0d] got=%b/%h/%0d exp=1/%h/%0d", k-1, out_valid, out_data, out_qid, ed[k-1], (k-1) % 2); end
            end
            tick();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rr_end_valid got=%b exp=0", out_valid); end
        vectors++; if (pop_total !== 16'd8) begin miscompares++; $display("FAIL rr_total got=%0d exp=8", pop_total); end
    endtask

    task automatic test_one_empty();
        logic [3:0] ed [3];
        ed = '{4'h9, 4'hA, 4'hB};
        push0(4'h9); push0(4'hA); push0(4'hB); #1;
        for (int k = 0; k <= 3; k++) begin
            if (k < 3) begin
                vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b0) begin miscompares++; $display("FAIL q1e_pop[%0d] got=%b/%0d exp=1/0", k, fifo_pop, fifo_pop_sel); end
            end else begin
                vectors++; if (fifo_pop !== 1'b0 || fifo_pop_sel !== 1'b1) begin miscompares++; $display("FAIL q1e_rrptr got=%b/%0d exp=0/1", fifo_pop, fifo_pop_sel); end
            end
            if (k > 0) begin
                vectors++; if (out_data !== ed[k-1] || out_qid !== 1'b0) begin miscompares++; $display("FAIL q1e_out[%0d] got=%h/%0d exp=%h/0", k-1, out_data, out_qid, ed[k-1]); end
            end
            tick();
        end
        vectors++; if (pop_total !== 16'd11) begin miscompares++; $display("FAIL q1e_total got=%0d exp=11", pop_total); end
    endtask

    task automatic test_backpressure();
        logic [3:0] ed [4];
        logic       eq [4];
        logic       ep [4];
        logic       es [4];
        ed = '{4'h1, 4'h5, 4'h2, 4'h3};
        eq = '{1'b0, 1'b1, 1'b0, 1'b0};
        ep = '{1'b1, 1'b1, 1'b1, 1'b0};
        es = '{1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b0;
        push0(4'h1); push0(4'h2); push0(4'h3); push1(4'h4); push1(4'h5); #1;
        vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b1) begin miscompares++; $display("FAIL bp_pop0 got=%b/%0d exp=1/1", fifo_pop, fifo_pop_sel); end
        tick();
        vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b0) begin miscompares++; $display("FAIL bp_pop1 got=%b/%0d exp=1/0", fifo_pop, fifo_pop_sel); end
        tick();
        for (int k = 0; k < 3; k++) begin
            vectors++; if (fifo_pop !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'h4 || out_qid !== 1'b1) begin miscompares++; $display("FAIL bp_hold[%0d] got=%b/%b/%h/%0d exp=0/1/4/1", k, fifo_pop, out_valid, out_data, out_qid); end
            tick();
        end
        out_ready = 1'b1; #1;
        vectors++; if (fifo_pop !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got=%b exp=0", fifo_pop); end
        tick();
        for (int k = 0; k < 4; k++) begin
            vectors++; if (fifo_pop !== ep[k] || (ep[k] && fifo_pop_sel !== es[k])) begin miscompares++; $display("FAIL bp_resume[%0d] got=%b/%0d exp=%b/%0d", k, fifo_pop, fifo_pop_sel, ep[k], es[k]); end
            vectors++; if (out_data !== ed[k] || out_qid !== eq[k]) begin miscompares++; $display("FAIL bp_out[%0d] got=%h/%0d exp=%h/%0d", k, out_data, out_qid, ed[k], eq[k]); end
            tick();
        end
        vectors++; if (out_valid !== 1'b0 || pop_total !== 16'd16) begin miscompares++; $display("FAIL bp_end got=%b/%0d exp=0/16", out_valid, pop_total); end
    endtask

    task automatic test_stop();
        out_ready = 1'b0;
        push0(4'h6); push0(4'h7); push1(4'hC); #1;
        vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b1) begin miscompares++; $display("FAIL st_pop0 got=%b/%0d exp=1/1", fifo_pop, fifo_pop_sel); end
        tick();
        tick();
        stop = 1'b1; out_ready = 1'b1; #1;
        vectors++; if (fifo_pop !== 1'b0 || idle !== 1'b0 || out_data !== 4'hC) begin miscompares++; $display("FAIL st_now got=%b/%b/%h exp=0/0/c", fifo_pop, idle, out_data); end
        tick();
        vectors++; if (fifo_pop !== 1'b0 || idle !== 1'b0 || out_data !== 4'h6 || out_qid !== 1'b0) begin miscompares++; $display("FAIL st_drain got=%b/%b/%h/%0d exp=0/0/6/0", fifo_pop, idle, out_data, out_qid); end
        tick();
        vectors++; if (out_valid !== 1'b0 || idle !== 1'b1 || fifo_pop_sel !== 1'b1) begin miscompares++; $display("FAIL st_idle got=%b/%b/%0d exp=0/1/1", out_valid, idle, fifo_pop_sel); end
        push1(4'hD); #1;
        vectors++; if (fifo_pop !== 1'b0) begin miscompares++; $display("FAIL st_hold got=%b exp=0", fifo_pop); end
        stop = 1'b0; #1;
        vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b1 || idle !== 1'b0) begin miscompares++; $display("FAIL st_restart got=%b/%0d/%b exp=1/1/0", fifo_pop, fifo_pop_sel, idle); end
        tick();
        vectors++; if (out_data !== 4'hD || out_qid !== 1'b1 || fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b0) begin miscompares++; $display("FAIL st_next got=%h/%0d/%b/%0d exp=d/1/1/0", out_data, out_qid, fifo_pop, fifo_pop_sel); end
        tick();
        vectors++; if (out_data !== 4'h7 || fifo_pop !== 1'b0) begin miscompares++; $display("FAIL st_last got=%h/%b exp=7/0", out_data, fifo_pop); end
        tick();
        vectors++; if (out_valid !== 1'b0 || pop_total !== 16'd20) begin miscompares++; $display("FAIL st_end got=%b/%0d exp=0/20", out_valid, pop_total); end
    endtask

    task automatic test_enable();
        q_enable = 2'b01;
        push0(4'h1); push1(4'h2); #1;
        vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b0) begin miscompares++; $display("FAIL en_pop got=%b/%0d exp=1/0", fifo_pop, fifo_pop_sel); end
        tick();
        vectors++; if (fifo_pop !== 1'b0 || fifo_pop_sel !== 1'b1 || out_data !== 4'h1) begin miscompares++; $display("FAIL en_masked got=%b/%0d/%h exp=0/1/1", fifo_pop, fifo_pop_sel, out_data); end
        q_enable = 2'b11; #1;
        vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b1) begin miscompares++; $display("FAIL en_unmask got=%b/%0d exp=1/1", fifo_pop, fifo_pop_sel); end
        tick();
        vectors++; if (out_data !== 4'h2 || out_qid !== 1'b1 || fifo_pop !== 1'b0) begin miscompares++; $display("FAIL en_out got=%h/%0d/%b exp=2/1/0", out_data, out_qid, fifo_pop); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        push0(4'hE); #1;
        vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== 1'b0) begin miscompares++; $display("FAIL rm_pop got=%b/%0d exp=1/0", fifo_pop, fifo_pop_sel); end
        tick();
        vectors++; if (out_valid !== 1'b1 || fifo_pop_sel !== 1'b1) begin miscompares++; $display("FAIL rm_pre got=%b/%0d exp=1/1", out_valid, fifo_pop_sel); end
        rst = 1'b1; tick();
        vectors++; if (out_valid !== 1'b0 || pop_total !== 16'd0 || fifo_pop_sel !== 1'b0) begin miscompares++; $display("FAIL rm_post got=%b/%0d/%0d exp=0/0/0", out_valid, pop_total, fifo_pop_sel); end
        rst = 1'b0; tick();
        vectors++; if (out_valid !== 1'b0 || pop_total !== 16'd0) begin miscompares++; $display("FAIL rm_rel got=%b/%0d exp=0/0", out_valid, pop_total); end
    endtask

    task automatic test_order();
        logic [3:0] ed [3];
        logic       eq [3];
        logic       es [3];
        ed = '{4'hA, 4'hC, 4'hB};
        eq = '{1'b0, 1'b1, 1'b0};
        es = '{1'b0, 1'b1, 1'b0};
        stop = 1'b1;
        push0(4'hA); push0(4'hB); push1(4'hC);
        out_ready = 1'b1; stop = 1'b0; #1;
        for (int k = 0; k <= 3; k++) begin
            if (k < 3) begin
                vectors++; if (fifo_pop !== 1'b1 || fifo_pop_sel !== es[k]) begin miscompares++; $display("FAIL ord_pop[%0d] got=%b/%0d exp=1/%0d", k, fifo_pop, fifo_pop_sel, es[k]); end
            end else begin
                vectors++; if (fifo_pop !== 1'b0) begin miscompares++; $display("FAIL ord_done got=%b exp=0", fifo_pop); end
            end
            if (k > 0) begin
                vectors++; if (out_valid !== 1'b1 || out_data !== ed[k-1] || out_qid !== eq[k-1]) begin miscompares++; $display("FAIL ord_out[%0d] got=%b/%h/%0d exp=1/%h/%0d", k-1, out_valid, out_data, out_qid, ed[k-1], eq[k-1]); end
            end
            tick();
        end
        vectors++; if (out_valid !== 1'b0 || pop_total !== 16'd3) begin miscompares++; $display("FAIL ord_end got=%b/%0d exp=0/3", out_valid, pop_total); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_one_empty();
        test_backpressure();
        test_stop();
        test_enable();
        test_reset_mid();
        test_order();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
